alu_exec: RTL and testbench

- Execute-stage ALU, directly downstream of the ALU control decoder; consumes its 3-bit OP code plus two operands from the register-read stage.
- add/sub/and/or/slt/nop complete in one clock; mul (shift-add) and div (restoring) iterate one bit per clock.
- A START/BUSY/DONE handshake lets the control unit stall the pipeline during multi-cycle ops.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_muldiv_iter.sv | 62 ++++++
 rtl/alu_exec.sv | 202 ++++++++++++++++++++
 tb/tb_alu_exec.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
// OP codes are common with the ALU control decoder.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared shift/accumulate datapath for iterative mul and div.
// acc holds product high / remainder, mq holds multiplier / quotient.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] lo_nxt,
    output logic [WIDTH-1:0] hi_nxt
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] opnd;
    logic             div_mode;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // One step: shift-add for mul, trial subtract for div
    always_comb begin
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
        shifted = {acc, mq[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - opnd;
        ge      = (shifted >= {1'b0, opnd});
        if (div_mode) begin
            hi_nxt = ge ? diff : shifted[WIDTH-1:0];
            lo_nxt = {mq[WIDTH-2:0], ge};
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], mq[WIDTH-1:1]};
        end
    end

    // Load operands on accept, then advance one bit per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            mq       <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc      <= '0;
            mq       <= is_div ? a_in : b_in;
            opnd     <= is_div ? b_in : a_in;
            div_mode <= is_div;
        end else if (step) begin
            acc <= hi_nxt;
            mq  <= lo_nxt;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with START/BUSY/DONE handshake.
// Optional ALU_SIGNED_MULDIV_EN: signed two's-complement mul/div.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] HI,
    output logic             ZERO,
    output logic             DIV0,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic             is_sc;
    logic             is_mul;
    logic             is_div;
    logic [WIDTH-1:0] sc_res;
    logic             b_zero;
    logic             load;
    logic             last;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] fin_lo;
    logic [WIDTH-1:0] fin_hi;

`ifdef ALU_SIGNED_MULDIV_EN
    logic               a_neg;
    logic               b_neg;
    logic               neg_lo;
    logic               neg_hi;
    logic [2*WIDTH-1:0] prod;
`endif

    assign BUSY   = (state != ST_IDLE);
    assign b_zero = (B == '0);
    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign load   = START && (state == ST_IDLE) &&
                    (is_mul || (is_div && !b_zero));

    // Decode OP; unknown codes fall through as nop
    always_comb begin
        is_sc  = 1'b0;
        is_mul = 1'b0;
        is_div = 1'b0;
        sc_res = '0;
        case (OP)
            OP_ADD: begin
                is_sc  = 1'b1;
                sc_res = A + B;
            end
            OP_SUB: begin
                is_sc  = 1'b1;
                sc_res = A - B;
            end
            OP_AND: begin
                is_sc  = 1'b1;
                sc_res = A & B;
            end
            OP_OR: begin
                is_sc  = 1'b1;
                sc_res = A | B;
            end
            OP_SLT: begin
                is_sc  = 1'b1;
                sc_res = {{(WIDTH-1){1'b0}},
                          ($signed(A) < $signed(B))};
            end
            OP_MUL:  is_mul = 1'b1;
            OP_DIV:  is_div = 1'b1;
            default: ;
        endcase
    end

    // Operand magnitudes fed to the iterative datapath
    always_comb begin
`ifdef ALU_SIGNED_MULDIV_EN
        a_neg = A[WIDTH-1];
        b_neg = B[WIDTH-1];
        a_mag = a_neg ? (~A + 1'b1) : A;
        b_mag = b_neg ? (~B + 1'b1) : B;
`else
        a_mag = A;
        b_mag = B;
`endif
    end

    // Final words on the last step, with sign applied if enabled
    always_comb begin
        fin_lo = lo_nxt;
        fin_hi = hi_nxt;
`ifdef ALU_SIGNED_MULDIV_EN
        prod = {hi_nxt, lo_nxt};
        if (state == ST_MUL) begin
            if (neg_lo)
                prod = ~prod + 1'b1;
            fin_lo = prod[WIDTH-1:0];
            fin_hi = prod[2*WIDTH-1:WIDTH];
        end else begin
            if (neg_lo)
                fin_lo = ~lo_nxt + 1'b1;
            if (neg_hi)
                fin_hi = ~hi_nxt + 1'b1;
        end
`endif
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (CLK),
        .rst_n  (RST_N),
        .load   (load),
        .step   (BUSY),
        .is_div (is_div),
        .a_in   (a_mag),
        .b_in   (b_mag),
        .lo_nxt (lo_nxt),
        .hi_nxt (hi_nxt)
    );

    // Control FSM and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            RESULT <= '0;
            HI     <= '0;
            ZERO   <= 1'b1;
            DIV0   <= 1'b0;
            DONE   <= 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        if (is_sc) begin
                            RESULT <= sc_res;
                            ZERO   <= (sc_res == '0);
                            DONE   <= 1'b1;
                        end else if (is_mul) begin
                            state <= ST_MUL;
                            cnt   <= '0;
`ifdef ALU_SIGNED_MULDIV_EN
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= a_neg ^ b_neg;
`endif
                        end else if (is_div && b_zero) begin
                            RESULT <= '1;
                            HI     <= A;
                            ZERO   <= 1'b0;
                            DIV0   <= 1'b1;
                            DONE   <= 1'b1;
                        end else if (is_div) begin
                            state <= ST_DIV;
                            cnt   <= '0;
`ifdef ALU_SIGNED_MULDIV_EN
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= a_neg;
`endif
                        end else begin
                            DONE <= 1'b1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state  <= ST_IDLE;
                        RESULT <= fin_lo;
                        HI     <= fin_hi;
                        ZERO   <= (fin_lo == '0);
                        DONE   <= 1'b1;
                        if (state == ST_DIV)
                            DIV0 <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec.
// Build with ALU_SIGNED_MULDIV_EN to exercise the signed mul/div path.
module tb_alu_exec;
    import alu_pkg::*;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [2:0]  OP;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] RESULT;
    logic [31:0] HI;
    logic        ZERO;
    logic        DIV0;
    logic        BUSY;
    logic        DONE;

    int vectors;
    int miscompares;

    alu_exec dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .OP     (OP),
        .A      (A),
        .B      (B),
        .RESULT (RESULT),
        .HI     (HI),
        .ZERO   (ZERO),
        .DIV0   (DIV0),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive a request, let the next edge accept it, then scramble inputs
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        START = 1'b1;
        OP    = op;
        A     = a;
        B     = b;
        @(posedge CLK);
        #1;
        START = 1'b0;
        OP    = OP_NOP;
        A     = $urandom;
        B     = $urandom;
    endtask

    // Advance until DONE, counting cycles and BUSY samples (bounded)
    task automatic wait_done(output int n, output int busy_n);
        n      = 0;
        busy_n = 0;
        while (DONE !== 1'b1 && n < 200) begin
            if (BUSY === 1'b1)
                busy_n++;
            @(posedge CLK);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        START = 1'b0;
        OP    = OP_NOP;
        A     = '0;
        B     = '0;
        #12;
        vectors++;
        if (RESULT !== 32'h0 || HI !== 32'h0 || ZERO !== 1'b1 ||
            DIV0 !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got R=%h H=%h Z=%b D0=%b B=%b D=%b, want 0 0 1 0 0 0",
                     RESULT, HI, ZERO, DIV0, BUSY, DONE);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single;
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        vectors++;
        if (DONE !== 1'b1 || RESULT !== 32'h0 || ZERO !== 1'b1) begin
            miscompares++;
            $display("FAIL add_wrap: got D=%b R=%h Z=%b, want 1 0 1", DONE, RESULT, ZERO);
        end
        @(posedge CLK);
        #1;
        vectors++;
        if (DONE !== 1'b0 || RESULT !== 32'h0) begin
            miscompares++;
            $display("FAIL done_pulse: got D=%b R=%h, want 0 0", DONE, RESULT);
        end
        issue(OP_SUB, 32'd5, 32'd7);
        vectors++;
        if (DONE !== 1'b1 || RESULT !== 32'hFFFF_FFFE || ZERO !== 1'b0) begin
            miscompares++;
            $display("FAIL sub: got D=%b R=%h Z=%b, want 1 fffffffe 0", DONE, RESULT, ZERO);
        end
        issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
        vectors++;
        if (RESULT !== 32'h00F0_1200) begin
            miscompares++;
            $display("FAIL and: got %h, want 00f01200", RESULT);
        end
        issue(OP_OR, 32'hF0F0_1234, 32'h0FF0_FF00);
        vectors++;
        if (RESULT !== 32'hFFF0_FF34) begin
            miscompares++;
            $display("FAIL or: got %h, want fff0ff34", RESULT);
        end
        issue(OP_SLT, 32'hFFFF_FFFE, 32'h1);
        vectors++;
        if (RESULT !== 32'h1 || ZERO !== 1'b0) begin
            miscompares++;
            $display("FAIL slt_neg: got R=%h Z=%b, want 1 0", RESULT, ZERO);
        end
        issue(OP_SLT, 32'h1, 32'hFFFF_FFFE);
        vectors++;
        if (RESULT !== 32'h0 || ZERO !== 1'b1 || HI !== 32'h0) begin
            miscompares++;
            $display("FAIL slt_pos: got R=%h Z=%b H=%h, want 0 1 0", RESULT, ZERO, HI);
        end
        issue(OP_ADD, 32'd40, 32'd2);
        issue(OP_NOP, 32'd9, 32'd9);
        vectors++;
        if (DONE !== 1'b1 || RESULT !== 32'd42 || ZERO !== 1'b0) begin
            miscompares++;
            $display("FAIL nop: got D=%b R=%h Z=%b, want 1 0000002a 0", DONE, RESULT, ZERO);
        end
    endtask

    task automatic test_mul;
        int n;
        int bn;
        issue(OP_MUL, 32'h0001_0000, 32'h0003_0000);
        wait_done(n, bn);
        vectors++;
        if (n != 32 || bn != 32 || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_timing: got cycles=%0d busy=%0d B=%b, want 32 32 0", n, bn, BUSY);
        end
        vectors++;
        if (HI !== 32'h3 || RESULT !== 32'h0 || ZERO !== 1'b1) begin
            miscompares++;
            $display("FAIL mul_val: got H=%h R=%h Z=%b, want 3 0 1", HI, RESULT, ZERO);
        end
`ifndef ALU_SIGNED_MULDIV_EN
        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, bn);
        vectors++;
        if (HI !== 32'hFFFF_FFFE || RESULT !== 32'h1 || ZERO !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_max: got H=%h R=%h Z=%b, want fffffffe 1 0", HI, RESULT, ZERO);
        end
`endif
    endtask

    task automatic test_div;
        int n;
        int bn;
        issue(OP_DIV, 32'd100, 32'd7);
        wait_done(n, bn);
        vectors++;
        if (n != 32 || RESULT !== 32'd14 || HI !== 32'd2 || DIV0 !== 1'b0) begin
            miscompares++;
            $display("FAIL div: got cycles=%0d R=%h H=%h D0=%b, want 32 e 2 0",
                     n, RESULT, HI, DIV0);
        end
        issue(OP_DIV, 32'd5, 32'd0);
        vectors++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || RESULT !== 32'hFFFF_FFFF ||
            HI !== 32'd5 || DIV0 !== 1'b1 || ZERO !== 1'b0) begin
            miscompares++;
            $display("FAIL div0: got D=%b B=%b R=%h H=%h D0=%b Z=%b, want 1 0 ffffffff 5 1 0",
                     DONE, BUSY, RESULT, HI, DIV0, ZERO);
        end
        issue(OP_ADD, 32'd1, 32'd2);
        vectors++;
        if (RESULT !== 32'd3 || HI !== 32'd5 || DIV0 !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_hi_div0: got R=%h H=%h D0=%b, want 3 5 1", RESULT, HI, DIV0);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int bn;
        issue(OP_DIV, 32'd200, 32'd9);
        repeat (5) @(posedge CLK);
        #1;
        START = 1'b1;
        OP    = OP_SUB;
        A     = 32'd50;
        B     = 32'd8;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_done(n, bn);
        vectors++;
        if (n != 26 || RESULT !== 32'd22 || HI !== 32'd2) begin
            miscompares++;
            $display("FAIL busy_ignore: got cycles=%0d R=%h H=%h, want 26 16 2", n, RESULT, HI);
        end
        issue(OP_SUB, 32'd50, 32'd8);
        vectors++;
        if (DONE !== 1'b1 || RESULT !== 32'd42 || HI !== 32'd2 || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b: got D=%b R=%h H=%h B=%b, want 1 2a 2 0", DONE, RESULT, HI, BUSY);
        end
    endtask

    task automatic test_reset_abort;
        bit seen;
        issue(OP_MUL, 32'd3, 32'd5);
        repeat (10) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        vectors++;
        if (RESULT !== 32'h0 || HI !== 32'h0 || ZERO !== 1'b1 ||
            DIV0 !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abort: got R=%h H=%h Z=%b D0=%b B=%b D=%b, want 0 0 1 0 0 0",
                     RESULT, HI, ZERO, DIV0, BUSY, DONE);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (DONE === 1'b1 || BUSY === 1'b1)
                seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL abort_quiet: got activity=1, want 0");
        end
    endtask

`ifdef ALU_SIGNED_MULDIV_EN
    task automatic test_signed;
        int n;
        int bn;
        issue(OP_MUL, 32'hFFFF_FFFD, 32'd7);
        wait_done(n, bn);
        vectors++;
        if ({HI, RESULT} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            miscompares++;
            $display("FAIL smul: got %h%h, want ffffffffffffffeb", HI, RESULT);
        end
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(n, bn);
        vectors++;
        if (RESULT !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF || DIV0 !== 1'b0) begin
            miscompares++;
            $display("FAIL sdiv: got R=%h H=%h D0=%b, want fffffffd ffffffff 0",
                     RESULT, HI, DIV0);
        end
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, bn);
        vectors++;
        if (RESULT !== 32'h8000_0000 || HI !== 32'h0) begin
            miscompares++;
            $display("FAIL sdiv_minneg: got R=%h H=%h, want 80000000 0", RESULT, HI);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset;
        test_single;
        test_mul;
        test_div;
        test_back_to_back;
`ifdef ALU_SIGNED_MULDIV_EN
        test_signed;
`endif
        test_reset_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
